// File: rtl/or_8_bits_pkg.sv
// Shared definitions for the structural 8-bit OR block: word width,
// word type and the result register's reset value.
package or_8_bits_pkg;

  localparam int WIDTH = 8;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t RESET_VALUE = '0;

endpackage

// File: rtl/or_1_bit.sv
// Single-bit OR cell; the 8-bit OR is built by replicating this cell per bit.
module or_1_bit (
  input  logic a,
  input  logic b,
  output logic s
);

  assign s = a | b;

endmodule

// File: rtl/or_8_bits_structure.sv
// Structural 8-bit OR with a registered copy of the result and a valid flag.
// Defining OR_8_BITS_STRUCTURE_ZERO_FLAG_EN adds the registered ZERO flag.
module or_8_bits_structure #(
  parameter int WIDTH = or_8_bits_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EN,
  output logic [WIDTH-1:0] S,
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
  output logic             ZERO,
`endif
  output logic [WIDTH-1:0] S_REG,
  output logic             S_VALID
);

  import or_8_bits_pkg::*;

  logic [WIDTH-1:0] orBits;

  // One OR cell per bit; S is purely combinational and ignores clk/rst/EN.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    or_1_bit u_or_1_bit (
      .a(A[i]),
      .b(B[i]),
      .s(orBits[i])
    );
  end

  assign S = orBits;

  // Reset wins over EN; with EN low the captured result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_REG   <= RESET_VALUE;
      S_VALID <= 1'b0;
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
      ZERO    <= 1'b1;
`endif
    end else if (EN) begin
      S_REG   <= orBits;
      S_VALID <= 1'b1;
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
      ZERO    <= (orBits == '0);
`endif
    end
  end

endmodule

// File: tb/tb_or_8_bits_structure.sv
// Directed self-checking bench for or_8_bits_structure, including an
// exhaustive sweep of the combinational output. Works with or without
// OR_8_BITS_STRUCTURE_ZERO_FLAG_EN defined.
module tb_or_8_bits_structure;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       en;
  logic [7:0] s;
  logic [7:0] sReg;
  logic       sValid;
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;

  or_8_bits_structure dut (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .EN(en),
    .S(s),
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
    .ZERO(zero),
`endif
    .S_REG(sReg),
    .S_VALID(sValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, well away from the capturing edge.
  task automatic applyStimulus(input logic [7:0] newA, input logic [7:0] newB,
                               input logic newEn, input logic newRst);
    @(negedge clk);
    a   = newA;
    b   = newB;
    en  = newEn;
    rst = newRst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic checkZero(input string tag, input logic expected);
`ifdef OR_8_BITS_STRUCTURE_ZERO_FLAG_EN
    checkOutput(tag, {7'd0, zero}, {7'd0, expected});
`endif
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a = 8'h00; b = 8'h00; en = 1'b0; rst = 1'b1;

    // Reset with EN high: reset must win; S still follows A|B.
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    checkOutput("rst_s", s, 8'hFF);
    clockEdge();
    checkOutput("rst_sreg", sReg, 8'h00);
    checkOutput("rst_valid", {7'd0, sValid}, 8'h00);
    checkZero("rst_zero", 1'b1);

    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
    checkOutput("ff00_s", s, 8'hFF);
    clockEdge();
    checkOutput("ff00_sreg", sReg, 8'hFF);
    checkOutput("ff00_valid", {7'd0, sValid}, 8'h01);
    checkZero("ff00_zero", 1'b0);

    applyStimulus(8'hFF, 8'hA9, 1'b1, 1'b0);
    checkOutput("ffa9_s", s, 8'hFF);
    clockEdge();
    checkOutput("ffa9_sreg", sReg, 8'hFF);

    applyStimulus(8'h30, 8'h0C, 1'b1, 1'b0);
    checkOutput("300c_s", s, 8'h3C);
    clockEdge();
    checkOutput("300c_sreg", sReg, 8'h3C);

    // EN low: register holds the previous capture.
    applyStimulus(8'h9D, 8'h9F, 1'b0, 1'b0);
    checkOutput("9d9f_s", s, 8'h9F);
    clockEdge();
    checkOutput("9d9f_hold", sReg, 8'h3C);
    checkOutput("9d9f_valid", {7'd0, sValid}, 8'h01);
    checkZero("9d9f_zero", 1'b0);

    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("0000_s", s, 8'h00);
    clockEdge();
    checkOutput("0000_sreg", sReg, 8'h00);
    checkOutput("0000_valid", {7'd0, sValid}, 8'h01);
    checkZero("0000_zero", 1'b1);

    // Back-to-back loads.
    applyStimulus(8'h01, 8'h02, 1'b1, 1'b0);
    clockEdge();
    checkOutput("b2b1_sreg", sReg, 8'h03);
    checkZero("b2b1_zero", 1'b0);
    applyStimulus(8'h80, 8'h40, 1'b1, 1'b0);
    clockEdge();
    checkOutput("b2b2_sreg", sReg, 8'hC0);

    // Load FF, then reset mid-operation with EN high.
    applyStimulus(8'hF0, 8'h0F, 1'b1, 1'b0);
    clockEdge();
    checkOutput("preRst_sreg", sReg, 8'hFF);
    applyStimulus(8'h0F, 8'h30, 1'b1, 1'b1);
    checkOutput("midRst_s_pre", s, 8'h3F);
    clockEdge();
    checkOutput("midRst_s_post", s, 8'h3F);
    checkOutput("midRst_sreg", sReg, 8'h00);
    checkOutput("midRst_valid", {7'd0, sValid}, 8'h00);
    checkZero("midRst_zero", 1'b1);

    // After reset, EN low keeps the cleared state.
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    clockEdge();
    checkOutput("postRst_sreg", sReg, 8'h00);
    checkOutput("postRst_valid", {7'd0, sValid}, 8'h00);

    // Exhaustive sweep of the combinational path.
    en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        logic [7:0] expOr;
        a = i[7:0];
        b = j[7:0];
        expOr = i[7:0] | j[7:0];
        #1;
        checkOutput("sweep_s", s, expOr);
      end
    end
    checkOutput("sweep_sreg_held", sReg, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
